boot_rom_arbiter: RTL and testbench
===================================

BOOT_ROM_ARBITER -- requirements
Module: boot_rom_arbiter

Interface
REQ-001 Parameter ROM_DEPTH, default 548, is the number of valid 32-bit words in the boot ROM.
REQ-002 Parameter ROM_AW, default 10, is the ROM word-address width.
REQ-003 Port CLK  input  1  is the clock; all state updates on its rising edge.
REQ-004 Port RSTN  input  1  is the reset: synchronous, active-low.
REQ-005 Ports i_req/d_req  input  1  are the instruction-side and data-side read requests.
REQ-006 Ports i_addr/d_addr  input  32  are the byte addresses; bits [ROM_AW+1:2] select the word.
REQ-007 Ports i_gnt/d_gnt  output  1  are the combinational grants, valid in the request cycle.
REQ-008 Ports i_rvalid/d_rvalid  output  1  mark response data valid.
REQ-009 Ports i_rdata/d_rdata  output  32  carry the response data.
REQ-010 Ports i_err/d_err  output  1  flag an out-of-range response, qualified by rvalid.
REQ-011 Port rom_csn  output  1  is the active-low ROM chip select.
REQ-012 Port rom_addr  output  ROM_AW  is the ROM word address.
REQ-013 Port rom_rdata  input  32  is the ROM data, valid the cycle after rom_csn=0 is sampled.

Function
REQ-014 Handshake: a transfer occurs in any cycle with req=1 and gnt=1; at most one grant per cycle.
REQ-015 Single requester: the block SHALL grant it in the same cycle.
REQ-016 Both requesting: the block SHALL grant the port not granted most recently (round-robin pointer last_port).
REQ-017 last_port SHALL update to the granted port on every transfer and hold otherwise.
REQ-018 A non-granted requester SHALL hold req and addr stable; the block samples addr only on grant.
REQ-019 On a transfer, rom_csn=0 and rom_addr=addr[ROM_AW+1:2] of the winner, in the same cycle.
REQ-020 No transfer: rom_csn=1; rom_addr holds its last value.
REQ-021 Latency is exactly 1 cycle: the granted port's rvalid=1 in cycle N+1, with rdata=rom_rdata.
REQ-022 Back-to-back transfers SHALL be supported at one per cycle, either port, no bubbles.
REQ-023 The registered response owner (resp_port, resp_valid) SHALL steer rvalid; the other port's rvalid=0.
REQ-024 The non-responding port's rdata SHALL be 0.
REQ-025 Addresses with bits [1:0]≠0 SHALL be word-aligned by truncation; no error.

Reset
REQ-026 While RSTN=0 at a clock edge, resp_valid SHALL clear to 0 and last_port SHALL be set to d (instruction wins the first conflict).
REQ-027 During reset, all gnt, rvalid and err outputs SHALL be 0, rom_csn=1, and rom_addr=0.
REQ-028 A response pending when reset is asserted SHALL be dropped, with no rvalid after reset release.
REQ-029 Requests SHALL be accepted in the first cycle after reset deasserts.

Configuration
REQ-030 Macro BOOT_ROM_RANGE_CHECK_EN controls the range check.
REQ-031 With the macro defined, a granted word index ≥ ROM_DEPTH or nonzero addr[31:ROM_AW+2] SHALL still be granted, but rom_csn=1.
REQ-032 With the macro defined, such an out-of-range access SHALL produce rvalid=1, rdata=0 and err=1 in cycle N+1.
REQ-033 Without the macro, there is no range check: the address is truncated to ROM_AW bits (wraps), and err is tied to 0.

Verification
REQ-034 i_req=1, i_addr=0x80, d_req=0 -> i_gnt=1 and rom_addr=0x20 in cycle N; i_rvalid=1 and i_rdata=rom word 0x20 in N+1.
REQ-035 Reset, then both req every cycle for 4 cycles -> grants alternate i,d,i,d; rvalids follow one cycle later in the same order.
REQ-036 d_req held continuously with i_req pulsed every other cycle -> no port is starved; d granted at least every second cycle.
REQ-037 With macro: d_addr=0x0000_0890 (index 548) -> d_gnt=1, rom_csn=1; next cycle d_rvalid=1, d_err=1, d_rdata=0. Without macro: rom_addr=0x224, d_err=0.
REQ-038 Grant in cycle N, RSTN=0 in N+1 -> no rvalid in N+1 or after release; next conflict grants i first.

Source files
------------

// File: rtl/boot_rom_arbiter.sv
// ============================================================================
// boot_rom_arbiter: round-robin I/D arbiter onto a single-cycle boot ROM.
// Optional range check enabled by macro BOOT_ROM_RANGE_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module boot_rom_arbiter #(
  parameter int ROM_DEPTH = 548,
  parameter int ROM_AW    = 10
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              rom_csn,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata
);

  localparam logic        c_PORT_I    = 1'b0;
  localparam logic        c_PORT_D    = 1'b1;
  localparam logic [31:0] c_ROM_DEPTH = ROM_DEPTH;

  logic              last_port_q, last_port_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_port_q, resp_port_d;
  logic              resp_err_q, resp_err_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

  logic              w_i_gnt;
  logic              w_d_gnt;
  logic              w_xfer;
  logic [31:0]       w_win_addr;
  logic [ROM_AW-1:0] w_win_idx;
  logic              w_oor;
  logic              w_unused_ok;
  logic              w_resp;
  logic [31:0]       w_rdata;

  // On conflict the port that did not win last time gets the grant.
  assign w_i_gnt    = RSTN & i_req & (~d_req | (last_port_q == c_PORT_D));
  assign w_d_gnt    = RSTN & d_req & (~i_req | (last_port_q == c_PORT_I));
  assign w_xfer     = w_i_gnt | w_d_gnt;
  assign w_win_addr = w_d_gnt ? d_addr : i_addr;
  assign w_win_idx  = w_win_addr[ROM_AW+1:2];

`ifdef BOOT_ROM_RANGE_CHECK_EN
  assign w_oor       = w_xfer & ((32'(w_win_idx) >= c_ROM_DEPTH) | (|w_win_addr[31:ROM_AW+2]));
  assign w_unused_ok = ^w_win_addr[1:0];
`else
  assign w_oor       = 1'b0;
  assign w_unused_ok = ^{w_win_addr[31:ROM_AW+2], w_win_addr[1:0]};
`endif

  always_comb begin
    resp_valid_d = w_xfer;
    resp_port_d  = w_d_gnt;
    resp_err_d   = w_oor;
    last_port_d  = w_xfer ? w_d_gnt : last_port_q;
    rom_addr_d   = w_xfer ? w_win_idx : rom_addr_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      last_port_q  <= c_PORT_D;
      resp_valid_q <= 1'b0;
      resp_port_q  <= c_PORT_I;
      resp_err_q   <= 1'b0;
      rom_addr_q   <= '0;
    end else begin
      last_port_q  <= last_port_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_err_q   <= resp_err_d;
      rom_addr_q   <= rom_addr_d;
    end
  end

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign rom_csn  = ~(w_xfer & ~w_oor);
  assign rom_addr = RSTN ? rom_addr_d : '0;

  // Out-of-range responses never expose whatever the ROM bus carries.
  assign w_resp   = RSTN & resp_valid_q;
  assign w_rdata  = resp_err_q ? 32'd0 : rom_rdata;
  assign i_rvalid = w_resp & (resp_port_q == c_PORT_I);
  assign d_rvalid = w_resp & (resp_port_q == c_PORT_D);
  assign i_rdata  = i_rvalid ? w_rdata : 32'd0;
  assign d_rdata  = d_rvalid ? w_rdata : 32'd0;
  assign i_err    = i_rvalid & resp_err_q;
  assign d_err    = d_rvalid & resp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_rom_arbiter.sv
// ============================================================================
// tb_boot_rom_arbiter: directed self-checking bench for boot_rom_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_boot_rom_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        rom_csn;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;

  int n_run  = 0;
  int n_fail = 0;

  boot_rom_arbiter #(.ROM_DEPTH(548), .ROM_AW(10)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .rom_csn(rom_csn), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return {12'hB07, 10'd0, a};
  endfunction

  // ROM model: data for the sampled address the cycle after csn is low.
  always @(posedge CLK) rom_rdata <= rom_csn ? 32'hDEAD_BEEF : rom_word(rom_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    RSTN = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h80; d_addr = 32'h84;
    @(negedge CLK); @(negedge CLK); #1;
    n_run++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_i_gnt: got %b want 0", i_gnt); end
    n_run++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt); end
    n_run++; if (rom_csn !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %b want 1", rom_csn); end
    n_run++; if (rom_addr !== 10'h0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    n_run++; if ({i_rvalid, d_rvalid, i_err, d_err} !== 4'b0) begin n_fail++; $display("FAIL reset_rvalid_err: got %b want 0000", {i_rvalid, d_rvalid, i_err, d_err}); end
  endtask

  // First cycle after reset release also checks immediate acceptance.
  task automatic test_single_i();
    @(negedge CLK);
    RSTN = 1'b1; i_req = 1'b1; d_req = 1'b0; i_addr = 32'h80; #1;
    n_run++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL single_i_gnt: got %b want 1", i_gnt); end
    n_run++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL single_d_gnt: got %b want 0", d_gnt); end
    n_run++; if (rom_csn !== 1'b0) begin n_fail++; $display("FAIL single_csn: got %b want 0", rom_csn); end
    n_run++; if (rom_addr !== 10'h20) begin n_fail++; $display("FAIL single_rom_addr: got %h want 020", rom_addr); end
    @(negedge CLK);
    i_req = 1'b0; #1;
    n_run++; if (i_rvalid !== 1'b1) begin n_fail++; $display("FAIL single_i_rvalid: got %b want 1", i_rvalid); end
    n_run++; if (i_rdata !== rom_word(10'h20)) begin n_fail++; $display("FAIL single_i_rdata: got %h want %h", i_rdata, rom_word(10'h20)); end
    n_run++; if (d_rvalid !== 1'b0 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL single_d_idle: got rvalid=%b rdata=%h want 0/0", d_rvalid, d_rdata); end
    n_run++; if (rom_csn !== 1'b1 || rom_addr !== 10'h20) begin n_fail++; $display("FAIL single_idle_hold: got csn=%b addr=%h want 1/020", rom_csn, rom_addr); end
  endtask

  task automatic test_alternate();
    logic exp_i;
    @(negedge CLK);
    RSTN = 1'b0; i_req = 1'b0; d_req = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h204;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2 == 0);
      #1;
      n_run++; if (i_gnt !== exp_i || d_gnt !== ~exp_i) begin n_fail++; $display("FAIL alt_gnt[%0d]: got i=%b d=%b want i=%b", k, i_gnt, d_gnt, exp_i); end
      n_run++; if (rom_addr !== (exp_i ? 10'h40 : 10'h81)) begin n_fail++; $display("FAIL alt_rom_addr[%0d]: got %h", k, rom_addr); end
      if (k > 0) begin
        n_run++; if (i_rvalid !== ~exp_i || d_rvalid !== exp_i) begin n_fail++; $display("FAIL alt_rvalid[%0d]: got i=%b d=%b", k, i_rvalid, d_rvalid); end
        n_run++; if ((exp_i ? d_rdata : i_rdata) !== (exp_i ? rom_word(10'h81) : rom_word(10'h40))) begin n_fail++; $display("FAIL alt_rdata[%0d]: got i=%h d=%h", k, i_rdata, d_rdata); end
      end
      @(negedge CLK);
    end
    i_req = 1'b0; d_req = 1'b0; #1;
    n_run++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin n_fail++; $display("FAIL alt_last_rvalid: got i=%b d=%b want 0/1", i_rvalid, d_rvalid); end
    n_run++; if (d_rdata !== rom_word(10'h81) || i_rdata !== 32'd0) begin n_fail++; $display("FAIL alt_last_rdata: got i=%h d=%h", i_rdata, d_rdata); end
  endtask

  // d held, i pulsed every other cycle; i_addr is unaligned (truncated).
  task automatic test_fairness();
    logic exp_i;
    i_addr = 32'h83; d_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      exp_i = (k % 2 == 0);
      i_req = exp_i; d_req = 1'b1; #1;
      n_run++; if (i_gnt !== exp_i || d_gnt !== ~exp_i) begin n_fail++; $display("FAIL fair_gnt[%0d]: got i=%b d=%b want i=%b", k, i_gnt, d_gnt, exp_i); end
      n_run++; if (rom_addr !== (exp_i ? 10'h20 : 10'h04)) begin n_fail++; $display("FAIL fair_rom_addr[%0d]: got %h", k, rom_addr); end
    end
    @(negedge CLK);
    i_req = 1'b0; d_req = 1'b0; #1;
    n_run++; if (d_rvalid !== 1'b1 || d_err !== 1'b0) begin n_fail++; $display("FAIL fair_last: got rvalid=%b err=%b want 1/0", d_rvalid, d_err); end
  endtask

  task automatic test_range();
    @(negedge CLK);
    i_req = 1'b0; d_req = 1'b1; d_addr = 32'h88C; #1;
    n_run++; if (d_gnt !== 1'b1 || rom_csn !== 1'b0 || rom_addr !== 10'h223) begin n_fail++; $display("FAIL range_547: got gnt=%b csn=%b addr=%h", d_gnt, rom_csn, rom_addr); end
    @(negedge CLK);
    d_addr = 32'h890; #1;
    n_run++; if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== rom_word(10'h223)) begin n_fail++; $display("FAIL range_547_resp: got v=%b e=%b d=%h", d_rvalid, d_err, d_rdata); end
`ifdef BOOT_ROM_RANGE_CHECK_EN
    n_run++; if (d_gnt !== 1'b1 || rom_csn !== 1'b1) begin n_fail++; $display("FAIL range_548: got gnt=%b csn=%b want 1/1", d_gnt, rom_csn); end
`else
    n_run++; if (d_gnt !== 1'b1 || rom_csn !== 1'b0 || rom_addr !== 10'h224) begin n_fail++; $display("FAIL range_548: got gnt=%b csn=%b addr=%h", d_gnt, rom_csn, rom_addr); end
`endif
    @(negedge CLK);
    d_addr = 32'h1000_0004; #1;
`ifdef BOOT_ROM_RANGE_CHECK_EN
    n_run++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL range_548_resp: got v=%b e=%b d=%h want 1/1/0", d_rvalid, d_err, d_rdata); end
    n_run++; if (d_gnt !== 1'b1 || rom_csn !== 1'b1) begin n_fail++; $display("FAIL range_high: got gnt=%b csn=%b want 1/1", d_gnt, rom_csn); end
`else
    n_run++; if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== rom_word(10'h224)) begin n_fail++; $display("FAIL range_548_resp: got v=%b e=%b d=%h", d_rvalid, d_err, d_rdata); end
    n_run++; if (d_gnt !== 1'b1 || rom_csn !== 1'b0 || rom_addr !== 10'h001) begin n_fail++; $display("FAIL range_high: got gnt=%b csn=%b addr=%h", d_gnt, rom_csn, rom_addr); end
`endif
    @(negedge CLK);
    d_req = 1'b0; #1;
`ifdef BOOT_ROM_RANGE_CHECK_EN
    n_run++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'd0) begin n_fail++; $display("FAIL range_high_resp: got v=%b e=%b d=%h want 1/1/0", d_rvalid, d_err, d_rdata); end
`else
    n_run++; if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== rom_word(10'h001)) begin n_fail++; $display("FAIL range_high_resp: got v=%b e=%b d=%h", d_rvalid, d_err, d_rdata); end
`endif
    n_run++; if (i_rvalid !== 1'b0 || i_err !== 1'b0 || rom_csn !== 1'b1 || rom_addr !== 10'h001) begin n_fail++; $display("FAIL range_idle: got iv=%b ie=%b csn=%b addr=%h", i_rvalid, i_err, rom_csn, rom_addr); end
  endtask

  task automatic test_reset_drop();
    @(negedge CLK);
    i_req = 1'b1; d_req = 1'b0; i_addr = 32'h40; #1;
    n_run++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL drop_gnt: got %b want 1", i_gnt); end
    @(posedge CLK); #1;
    RSTN = 1'b0; i_req = 1'b0; #1;
    n_run++; if (i_rvalid !== 1'b0 || rom_csn !== 1'b1 || rom_addr !== 10'h0) begin n_fail++; $display("FAIL drop_in_reset: got v=%b csn=%b addr=%h", i_rvalid, rom_csn, rom_addr); end
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1; i_req = 1'b1; d_req = 1'b1; d_addr = 32'h8; #1;
    n_run++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_after_release: got i=%b d=%b want 0/0", i_rvalid, d_rvalid); end
    n_run++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL drop_first_conflict: got i=%b d=%b want 1/0", i_gnt, d_gnt); end
    @(negedge CLK);
    i_req = 1'b0; d_req = 1'b0; #1;
    n_run++; if (i_rvalid !== 1'b1 || i_rdata !== rom_word(10'h10)) begin n_fail++; $display("FAIL drop_resume: got v=%b d=%h want 1/%h", i_rvalid, i_rdata, rom_word(10'h10)); end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_alternate();
    test_fairness();
    test_range();
    test_reset_drop();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
